// File: rtl/button_controller.sv
// button_controller
// Memory-mapped input port for 8 push-buttons on the CPU I/O bus.
// Each raw pin is synchronised (2 FFs) and debounced. Press edges are
// latched into a clear-on-read PENDING register. A level interrupt is
// raised while any unmasked bit is pending.
//
// Register map (I/O space, mio == 0):
//   BASE_ADDRESS + 0 : STATE   (R)  debounced button levels
//   BASE_ADDRESS + 1 : PENDING (R)  press edges, cleared by the read
//   BASE_ADDRESS + 2 : MASK    (RW) interrupt enable per bit, resets to FF
//
// Ports:
//   clock       - system clock, all state changes on posedge
//   reset       - asynchronous, active-low reset
//   buttons     - raw asynchronous pins, 1 = pressed
//   addressBus  - CPU address
//   dataBusIn   - CPU write data (MASK only)
//   readRequest - 1 = read, 0 = write
//   mio         - 0 = I/O space
//   enable      - bus cycle valid
//   dataBusOut  - read data, 0 when not selected (OR-combined upstream)
//   interrupt   - registered (pending & mask) != 0
module button_controller #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0010,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  buttons,
  input  logic [31:0] addressBus,
  input  logic [7:0]  dataBusIn,
  input  logic        readRequest,
  input  logic        mio,
  input  logic        enable,
  output logic [7:0]  dataBusOut,
  output logic        interrupt
);

  localparam logic [31:0] ADDR_STATE   = BASE_ADDRESS;
  localparam logic [31:0] ADDR_PENDING = BASE_ADDRESS + 32'd1;
  localparam logic [31:0] ADDR_MASK    = BASE_ADDRESS + 32'd2;
  localparam logic [15:0] CNT_LAST     = DEBOUNCE_CYCLES - 16'd1;

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_stable;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic       r_interrupt;

  logic [7:0] w_stable_next;
  logic [7:0] w_rise;
  logic [7:0] w_pending_next;
  logic [7:0] w_mask_next;
  logic [7:0] w_read_data;
  logic       w_sel;
  logic       w_rd;
  logic       w_wr;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce. The counter runs only while the synchronised pin
  // disagrees with the stable level; any return to the stable level
  // restarts it. On the last count the new level is accepted and the
  // counter returns to 0, so it never wraps.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      logic [15:0] r_cnt;
      logic        w_differs;
      logic        w_done;

      assign w_differs         = r_sync2[gi] ^ r_stable[gi];
      assign w_done            = w_differs && (r_cnt == CNT_LAST);
      assign w_stable_next[gi] = w_done ? r_sync2[gi] : r_stable[gi];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_cnt <= 16'd0;
        end else if (!w_differs || w_done) begin
          r_cnt <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  endgenerate

  // Press edge: stable is about to go 0 -> 1 on this posedge.
  assign w_rise = w_stable_next & ~r_stable;

  assign w_sel = enable && !mio;
  assign w_rd  = w_sel && readRequest;
  assign w_wr  = w_sel && !readRequest;

  always_comb begin
    w_read_data = 8'h00;
    if (w_rd) begin
      if (addressBus == ADDR_STATE) begin
        w_read_data = r_stable;
      end else if (addressBus == ADDR_PENDING) begin
        w_read_data = r_pending;
      end else if (addressBus == ADDR_MASK) begin
        w_read_data = r_mask;
      end
    end
  end

  // Clear only the bits actually returned by this read; a press landing
  // on the same edge is ORed back in so it is reported by the next read.
  always_comb begin
    w_pending_next = r_pending | w_rise;
    if (w_rd && (addressBus == ADDR_PENDING)) begin
      w_pending_next = (r_pending & ~w_read_data) | w_rise;
    end
    w_mask_next = r_mask;
    if (w_wr && (addressBus == ADDR_MASK)) begin
      w_mask_next = dataBusIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable    <= 8'h00;
      r_pending   <= 8'h00;
      r_mask      <= 8'hFF;
      r_interrupt <= 1'b0;
    end else begin
      r_stable    <= w_stable_next;
      r_pending   <= w_pending_next;
      r_mask      <= w_mask_next;
      r_interrupt <= |(w_pending_next & w_mask_next);
    end
  end

  // The read mux is combinational, so gate it with reset to keep the
  // shared bus quiet (MASK would otherwise read FF) while reset is held.
  assign dataBusOut = reset ? w_read_data : 8'h00;
  assign interrupt  = r_interrupt;

endmodule

// File: tb/tb_button_controller.sv
module tb_button_controller;

  localparam logic [31:0] BASE = 32'h10;

  logic        clock;
  logic        reset;
  logic [7:0]  buttons;
  logic [31:0] addressBus;
  logic [7:0]  dataBusIn;
  logic        readRequest;
  logic        mio;
  logic        enable;
  logic [7:0]  dataBusOut;
  logic        interrupt;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic        mio;
    logic        en;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t rst_vecs[6];
  vec_t dec_vecs[3];

  // Scoreboard: expected read data is queued when the read is driven and
  // popped when the combinational read data is sampled.
  logic [7:0] exp_q[$];
  string      name_q[$];

  button_controller #(
    .BASE_ADDRESS   (BASE),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .buttons    (buttons),
    .addressBus (addressBus),
    .dataBusIn  (dataBusIn),
    .readRequest(readRequest),
    .mio        (mio),
    .enable     (enable),
    .dataBusOut (dataBusOut),
    .interrupt  (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mkv(logic [31:0] a, logic m, logic e, logic [7:0] x, string n);
    vec_t v;
    v.addr = a;
    v.mio  = m;
    v.en   = e;
    v.exp  = x;
    v.name = n;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %02h", name, act);
    end
  endtask

  task automatic chk_irq(string name, logic exp);
    chk(name, {7'b0, interrupt}, {7'b0, exp});
  endtask

  task automatic pop_compare();
    logic [7:0] e;
    string      n;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, dataBusOut, e);
    end
  endtask

  // One bus read cycle; starts and ends just after a negedge, so exactly
  // one posedge (which ends the read) elapses.
  task automatic drive_read(logic [31:0] a, logic m, logic e, logic [7:0] x, string n);
    addressBus  = a;
    mio         = m;
    enable      = e;
    readRequest = 1'b1;
    exp_q.push_back(x);
    name_q.push_back(n);
    #1;
    pop_compare();
    @(negedge clock);
    enable = 1'b0;
    mio    = 1'b0;
  endtask

  task automatic rd_state(logic [7:0] x, string n);
    drive_read(BASE, 1'b0, 1'b1, x, n);
  endtask

  task automatic rd_pend(logic [7:0] x, string n);
    drive_read(BASE + 32'd1, 1'b0, 1'b1, x, n);
  endtask

  task automatic bus_write(logic [31:0] a, logic [7:0] d);
    addressBus  = a;
    dataBusIn   = d;
    mio         = 1'b0;
    readRequest = 1'b0;
    enable      = 1'b1;
    @(negedge clock);
    enable      = 1'b0;
    readRequest = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bounce_pat;

    rst_vecs[0] = mkv(32'h10, 1'b0, 1'b1, 8'h00, "rst_state");
    rst_vecs[1] = mkv(32'h11, 1'b0, 1'b1, 8'h00, "rst_pending");
    rst_vecs[2] = mkv(32'h12, 1'b0, 1'b1, 8'hFF, "rst_mask");
    rst_vecs[3] = mkv(32'h13, 1'b0, 1'b1, 8'h00, "unmapped_13");
    rst_vecs[4] = mkv(32'h12, 1'b1, 1'b1, 8'h00, "mask_mio1");
    rst_vecs[5] = mkv(32'h12, 1'b0, 1'b0, 8'h00, "mask_en0");
    dec_vecs[0] = mkv(32'h11, 1'b1, 1'b1, 8'h00, "dec_mio1");
    dec_vecs[1] = mkv(32'h11, 1'b0, 1'b0, 8'h00, "dec_en0");
    dec_vecs[2] = mkv(32'h14, 1'b0, 1'b1, 8'h00, "dec_addr14");
    bounce_pat  = 8'b1110_1110;

    reset = 1'b0; buttons = 8'h00; addressBus = 32'h0; dataBusIn = 8'h00;
    readRequest = 1'b1; mio = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk_irq("rst_irq", 1'b0);
    for (int i = 0; i < 6; i++)
      drive_read(rst_vecs[i].addr, rst_vecs[i].mio, rst_vecs[i].en, rst_vecs[i].exp, rst_vecs[i].name);

    // Clean press of bit 0: STATE flips after 2 sync + 4 debounce edges.
    buttons = 8'h01;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk_irq("press_irq_before", 1'b0);
      rd_state(8'h00, $sformatf("press_state_k%0d", k));
    end
    rd_state(8'h01, "press_state_k6");
    chk_irq("press_irq", 1'b1);
    rd_pend(8'h01, "press_pend_first");
    chk_irq("press_irq_cleared", 1'b0);
    rd_pend(8'h00, "press_pend_second");

    // Bounce on bit 2 never holds 4 cycles.
    for (int i = 0; i < 8; i++) begin
      buttons = {5'b0, bounce_pat[7-i], 2'b01};
      rd_state(8'h01, $sformatf("bounce_state_%0d", i));
    end
    buttons = 8'h01;
    rd_state(8'h01, "bounce_tail0");
    rd_state(8'h01, "bounce_tail1");
    rd_pend(8'h00, "bounce_pend");
    chk_irq("bounce_irq", 1'b0);
    buttons = 8'h05;
    for (int k = 0; k < 6; k++) rd_state(8'h01, $sformatf("hold_state_k%0d", k));
    rd_state(8'h05, "hold_state_k6");
    rd_pend(8'h04, "hold_pend");
    chk_irq("hold_irq_cleared", 1'b0);

    // Release only: no pending, no interrupt.
    buttons = 8'h00;
    for (int k = 0; k < 6; k++) rd_state(8'h05, $sformatf("rel_state_k%0d", k));
    rd_state(8'h00, "rel_state_k6");
    chk_irq("rel_irq", 1'b0);
    rd_pend(8'h00, "rel_pend");

    // Masked press: pending set but no interrupt until unmasked.
    bus_write(BASE + 32'd2, 8'hFE);
    buttons = 8'h01;
    for (int k = 0; k < 6; k++) rd_state(8'h00, $sformatf("mask_state_k%0d", k));
    rd_state(8'h01, "mask_state_k6");
    chk_irq("mask_irq_masked", 1'b0);
    drive_read(BASE + 32'd2, 1'b0, 1'b1, 8'hFE, "mask_readback");
    bus_write(BASE + 32'd2, 8'hFF);
    chk_irq("mask_irq_unmasked", 1'b1);
    rd_pend(8'h01, "mask_pend");
    chk_irq("mask_irq_cleared", 1'b0);

    // Read/edge collision: bit 3 qualifies on the edge ending the read.
    buttons = 8'h00;
    for (int k = 0; k < 6; k++) rd_state(8'h01, $sformatf("col_rel_k%0d", k));
    rd_state(8'h00, "col_rel_k6");
    buttons = 8'h01;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) buttons = 8'h09;
      rd_state((k >= 6) ? 8'h01 : 8'h00, $sformatf("col_state_k%0d", k));
    end
    rd_pend(8'h01, "col_pend_first");
    chk_irq("col_irq_between", 1'b1);
    rd_state(8'h09, "col_state_both");
    rd_pend(8'h08, "col_pend_second");
    chk_irq("col_irq_cleared", 1'b0);

    // Decode: set PENDING = 08 then probe with non-selecting reads.
    buttons = 8'h01;
    for (int k = 0; k < 6; k++) rd_state(8'h09, $sformatf("dec_rel_k%0d", k));
    rd_state(8'h01, "dec_rel_k6");
    buttons = 8'h09;
    for (int k = 0; k < 6; k++) rd_state(8'h01, $sformatf("dec_press_k%0d", k));
    rd_state(8'h09, "dec_press_k6");
    for (int i = 0; i < 3; i++)
      drive_read(dec_vecs[i].addr, dec_vecs[i].mio, dec_vecs[i].en, dec_vecs[i].exp, dec_vecs[i].name);
    chk_irq("dec_irq_kept", 1'b1);

    // Reset asserted mid-cycle during a PENDING read.
    addressBus = BASE + 32'd1; mio = 1'b0; readRequest = 1'b1; enable = 1'b1;
    exp_q.push_back(8'h08);
    name_q.push_back("dec_pend_unchanged");
    #1;
    pop_compare();
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_data", dataBusOut, 8'h00);
    chk_irq("rst_mid_irq", 1'b0);
    @(negedge clock);
    enable = 1'b0;
    drive_read(BASE + 32'd2, 1'b0, 1'b1, 8'h00, "rst_held_mask_read");
    chk_irq("rst_held_irq", 1'b0);

    // Buttons held through reset release: one press edge after 2 + 4 edges.
    reset = 1'b1;
    for (int k = 0; k < 6; k++) rd_state(8'h00, $sformatf("post_rst_k%0d", k));
    rd_state(8'h09, "post_rst_k6");
    chk_irq("post_rst_irq", 1'b1);
    rd_pend(8'h09, "post_rst_pend");
    rd_pend(8'h00, "post_rst_pend2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
